// File: rtl/code_frame_deserializer.sv
// rtl/code_frame_deserializer.sv - framed bit-serial command front-end for the code converter
//
// Receives 8-bit serial frames (start=1, sel[1:0], code[3:0], even parity P),
// presents the registered sel/code pair with a one-cycle strobe, flags codes the
// converter cannot map, and aborts frames that stall for TIMEOUT cycles.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ser_in, ser_valid   serial bit and its qualifier
//   code_in, select     last good frame's code and mode (held between frames)
//   frame_valid         one-cycle strobe when code_in/select update
//   range_err           qualifies frame_valid: code unmappable for the mode
//   parity_err          one-cycle strobe: frame dropped for bad parity
//   frame_abort         one-cycle strobe: frame dropped by the idle watchdog
//   busy                FSM is outside IDLE
//   frame_count         good-frame counter, wraps 255->0
module code_frame_deserializer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic [3:0] code_in,
  output logic [1:0] select,
  output logic       frame_valid,
  output logic       range_err,
  output logic       parity_err,
  output logic       frame_abort,
  output logic       busy,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {IDLE, SEL, CODE, PAR} state_t;

  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [3:0] code_q, code_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] count_q, count_d;
  logic       fv_q, fv_d;
  logic       re_q, re_d;
  logic       pe_q, pe_d;
  logic       fa_q, fa_d;
  logic       busy_q, busy_d;

  logic       parity_ok;
  logic       code_unmappable;

  // Payload is complete in shift_q when the parity bit arrives.
  assign parity_ok = ~(^{shift_q, ser_in});

  always_comb begin
    code_unmappable = 1'b0;
    case (shift_q[5:4])
      2'b01:   code_unmappable = (shift_q[3:0] > 4'd9);
      2'b11:   code_unmappable = (shift_q[3:0] < 4'd3) || (shift_q[3:0] > 4'd12);
      default: code_unmappable = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    code_d     = code_q;
    sel_d      = sel_q;
    count_d    = count_q;
    fv_d       = 1'b0;
    re_d       = 1'b0;
    pe_d       = 1'b0;
    fa_d       = 1'b0;

    if (state_q == IDLE) begin
      idle_cnt_d = '0;
      bit_cnt_d  = '0;
      if (ser_valid && ser_in) begin
        state_d = SEL;
        shift_d = '0;
      end
    end else if (ser_valid) begin
      idle_cnt_d = '0;
      case (state_q)
        SEL, CODE: begin
          shift_d   = {shift_q[4:0], ser_in};
          bit_cnt_d = bit_cnt_q + 3'd1;
          // bit_cnt spans the whole 6-bit payload: 0..1 select, 2..5 code.
          if (state_q == SEL && bit_cnt_q == 3'd1) state_d = CODE;
          if (state_q == CODE && bit_cnt_q == 3'd5) state_d = PAR;
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (parity_ok) begin
            sel_d   = shift_q[5:4];
            code_d  = shift_q[3:0];
            count_d = count_q + 8'd1;
            fv_d    = 1'b1;
            re_d    = code_unmappable;
          end else begin
            pe_d = 1'b1;
          end
        end
      endcase
    end else if (idle_cnt_q == IDLE_LIMIT) begin
      // This edge is the TIMEOUT-th consecutive stalled cycle.
      state_d    = IDLE;
      shift_d    = '0;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
      fa_d       = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      code_q     <= '0;
      sel_q      <= '0;
      count_q    <= '0;
      fv_q       <= 1'b0;
      re_q       <= 1'b0;
      pe_q       <= 1'b0;
      fa_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      code_q     <= code_d;
      sel_q      <= sel_d;
      count_q    <= count_d;
      fv_q       <= fv_d;
      re_q       <= re_d;
      pe_q       <= pe_d;
      fa_q       <= fa_d;
      busy_q     <= busy_d;
    end
  end

  assign code_in     = code_q;
  assign select      = sel_q;
  assign frame_valid = fv_q;
  assign range_err   = re_q;
  assign parity_err  = pe_q;
  assign frame_abort = fa_q;
  assign busy        = busy_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_code_frame_deserializer.sv
// tb/tb_code_frame_deserializer.sv - self-checking bench for code_frame_deserializer
module tb_code_frame_deserializer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n, ser_in, ser_valid;
  logic [3:0] code_in;
  logic [1:0] select;
  logic       frame_valid, range_err, parity_err, frame_abort, busy;
  logic [7:0] frame_count;

  code_frame_deserializer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .code_in(code_in), .select(select), .frame_valid(frame_valid),
    .range_err(range_err), .parity_err(parity_err), .frame_abort(frame_abort),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last good frame and good-frame count, plus expected strobes.
  logic [3:0] m_code;
  logic [1:0] m_sel;
  logic [7:0] m_cnt;
  logic       e_fv, e_re, e_pe;

  logic [15:0] got, exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame bits: [7]=start, [6:5]=sel, [4:1]=code, [0]=P.
  function automatic logic [7:0] mk(input logic [1:0] s, input logic [3:0] c, input logic bad);
    return {1'b1, s, c, (^{s, c}) ^ bad};
  endfunction

  task automatic drive_bits(input logic [7:0] bits, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      if (i > first) begin
        for (int g = 0; g < gap; g++) begin
          ser_valid = 1'b0;
          tick();
        end
      end
      ser_valid = 1'b1;
      ser_in    = bits[7-i];
      tick();
    end
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] bits);
    logic [1:0] s;
    logic [3:0] c;
    logic       good;
    s    = bits[6:5];
    c    = bits[4:1];
    good = ((bits[6] + bits[5] + bits[4] + bits[3] + bits[2] + bits[1] + bits[0]) % 2) == 0;
    e_fv = good;
    e_pe = !good;
    e_re = good && ((s == 2'd1 && c > 4'd9) || (s == 2'd3 && (c < 4'd3 || c > 4'd12)));
    if (good) begin
      m_sel  = s;
      m_code = c;
      m_cnt  = m_cnt + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    m_code = 4'd0; m_sel = 2'd0; m_cnt = 8'd0;
    got = {code_in, select, frame_valid, range_err, parity_err, frame_abort, busy, frame_count[4:0]};
    checks++;
    if (got !== 16'h0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset outputs got %h cnt %0d expected 0", got, frame_count);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] b;
    b = 8'b1001_0111;
    drive_bits(b, 0, 7, 0);
    model_frame(b);
    checks++;
    if ({frame_valid, range_err, parity_err, frame_abort, busy, select, code_in, frame_count} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1011, 8'd1}) begin
      errors++;
      $display("FAIL good_frame got fv%b re%b pe%b fa%b busy%b sel%b code%b cnt%0d expected 1 0 0 0 0 00 1011 1",
               frame_valid, range_err, parity_err, frame_abort, busy, select, code_in, frame_count);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0 || code_in !== 4'b1011 || select !== 2'b00) begin
      errors++;
      $display("FAIL good_frame_hold got fv%b code%b sel%b expected 0 1011 00", frame_valid, code_in, select);
    end
  endtask

  task automatic test_range();
    logic [1:0] s_tab [5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [3:0] c_tab [5] = '{4'b1100, 4'b0010, 4'b0011, 4'b1100, 4'b1101};
    logic       r_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = mk(s_tab[i], c_tab[i], 1'b0);
      drive_bits(b, 0, 7, 0);
      model_frame(b);
      checks++;
      if (frame_valid !== 1'b1 || range_err !== r_tab[i] || code_in !== c_tab[i] || select !== s_tab[i]) begin
        errors++;
        $display("FAIL range_%0d got fv%b re%b sel%b code%b expected 1 %b %b %b",
                 i, frame_valid, range_err, select, code_in, r_tab[i], s_tab[i], c_tab[i]);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] cnt_before;
    drive_bits(8'b1001_0111, 0, 7, 0);
    model_frame(8'b1001_0111);
    cnt_before = frame_count;
    drive_bits(8'b1001_0110, 0, 7, 0);
    model_frame(8'b1001_0110);
    checks++;
    if (parity_err !== 1'b1 || frame_valid !== 1'b0 || code_in !== 4'b1011 || frame_count !== cnt_before) begin
      errors++;
      $display("FAIL parity got pe%b fv%b code%b cnt%0d expected 1 0 1011 %0d",
               parity_err, frame_valid, code_in, frame_count, cnt_before);
    end
    tick();
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse got pe%b expected 0", parity_err);
    end
  endtask

  task automatic test_stall();
    drive_bits(8'b1001_0111, 0, 7, 3);
    model_frame(8'b1001_0111);
    got = {frame_valid, range_err, parity_err, frame_abort, select, code_in, 4'h0};
    exp = {e_fv, e_re, e_pe, 1'b0, m_sel, m_code, 4'h0};
    checks++;
    if (got !== exp || frame_count !== m_cnt) begin
      errors++;
      $display("FAIL stall got %h cnt %0d expected %h cnt %0d", got, frame_count, exp, m_cnt);
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] b;
    b = 8'b1010_0111;
    // TIMEOUT-1 idle cycles: frame survives.
    drive_bits(b, 0, 2, 0);
    for (int k = 1; k < TO; k++) tick();
    checks++;
    if (frame_abort !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_no_abort got fa%b busy%b expected 0 1", frame_abort, busy);
    end
    drive_bits(b, 3, 7, 0);
    model_frame(b);
    checks++;
    if (frame_valid !== 1'b1 || select !== m_sel || code_in !== m_code || frame_count !== m_cnt) begin
      errors++;
      $display("FAIL wd_complete got fv%b sel%b code%b cnt%0d expected 1 %b %b %0d",
               frame_valid, select, code_in, frame_count, m_sel, m_code, m_cnt);
    end
    // TIMEOUT idle cycles: frame aborts on the last one.
    drive_bits(b, 0, 2, 0);
    for (int k = 1; k < TO; k++) begin
      tick();
      checks++;
      if (frame_abort !== 1'b0) begin
        errors++;
        $display("FAIL wd_early idle %0d got fa%b expected 0", k, frame_abort);
      end
    end
    tick();
    checks++;
    if (frame_abort !== 1'b1 || busy !== 1'b0 || frame_valid !== 1'b0 || parity_err !== 1'b0 ||
        code_in !== m_code || select !== m_sel || frame_count !== m_cnt) begin
      errors++;
      $display("FAIL wd_abort got fa%b busy%b fv%b pe%b code%b cnt%0d expected 1 0 0 0 %b %0d",
               frame_abort, busy, frame_valid, parity_err, code_in, frame_count, m_code, m_cnt);
    end
    tick();
    checks++;
    if (frame_abort !== 1'b0) begin
      errors++;
      $display("FAIL wd_pulse got fa%b expected 0", frame_abort);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int gap, lead;
    for (int n = 0; n < 40; n++) begin
      b    = mk(2'($urandom_range(3)), 4'($urandom_range(15)), ($urandom_range(3) == 0));
      gap  = $urandom_range(2);
      lead = $urandom_range(2);
      for (int z = 0; z < lead; z++) begin
        ser_valid = 1'b1; ser_in = 1'b0;
        tick();
      end
      drive_bits(b, 0, 7, gap);
      model_frame(b);
      got = {frame_valid, range_err, parity_err, frame_abort, busy, select, code_in, 3'b0};
      exp = {e_fv, e_re, e_pe, 1'b0, 1'b0, m_sel, m_code, 3'b0};
      checks++;
      if (got !== exp || frame_count !== m_cnt) begin
        errors++;
        $display("FAIL random_%0d frame %b got %h cnt %0d expected %h cnt %0d", n, b, got, frame_count, exp, m_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_code = 4'd0; m_sel = 2'd0; m_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      b = mk(2'($urandom_range(3)), 4'($urandom_range(15)), 1'b0);
      drive_bits(b, 0, 7, 0);
      model_frame(b);
      checks++;
      if (frame_valid !== 1'b1 || range_err !== e_re || select !== m_sel || code_in !== m_code ||
          frame_count !== m_cnt) begin
        errors++;
        $display("FAIL b2b_%0d got fv%b re%b sel%b code%b cnt%0d expected 1 %b %b %b %0d",
                 n, frame_valid, range_err, select, code_in, frame_count, e_re, m_sel, m_code, m_cnt);
      end
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL b2b_wrap got cnt %0d expected 0", frame_count);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    drive_bits(8'b1001_0111, 0, 7, 0);
    model_frame(8'b1001_0111);
    b = mk(2'b10, 4'b0110, 1'b0);
    drive_bits(b, 0, 3, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_code = 4'd0; m_sel = 2'd0; m_cnt = 8'd0;
    got = {code_in, select, frame_valid, range_err, parity_err, frame_abort, busy, frame_count[4:0]};
    checks++;
    if (got !== 16'h0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got %h cnt %0d expected 0", got, frame_count);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0 || parity_err !== 1'b0 || frame_abort !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse got fv%b pe%b fa%b busy%b expected 0 0 0 0",
               frame_valid, parity_err, frame_abort, busy);
    end
    drive_bits(b, 0, 7, 0);
    model_frame(b);
    checks++;
    if (frame_valid !== 1'b1 || select !== 2'b10 || code_in !== 4'b0110 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_next got fv%b sel%b code%b cnt%0d expected 1 10 0110 1",
               frame_valid, select, code_in, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_range();
    test_parity();
    test_stall();
    test_watchdog();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_frame_deserializer.md
# code_frame_deserializer

Serial front-end stage that feeds the code converter. It receives framed bit-serial commands, checks even parity, and presents a registered 2-bit `select` and 4-bit `code_in` pair to the converter with a one-cycle `frame_valid` strobe. It also flags codes that the converter's BCD→Excess-3 or Excess-3→BCD modes cannot map. An idle watchdog aborts stalled frames.

## Interface

**Parameters**
- `TIMEOUT`, default 16: number of consecutive cycles with `ser_valid` low, mid-frame, that aborts the frame. Legal range is 2..255.

**Ports**
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ser_in` in 1: serial data bit.
- `ser_valid` in 1: when high, `ser_in` is sampled this cycle.
- `code_in` out 4: last good frame's code; drives the converter.
- `select` out 2: last good frame's mode; drives the converter.
- `frame_valid` out 1: one-cycle pulse when `code_in`/`select` are updated.
- `range_err` out 1: qualifies `frame_valid`; the code is unmappable for the selected mode.
- `parity_err` out 1: one-cycle pulse; the frame was discarded because of bad parity.
- `frame_abort` out 1: one-cycle pulse; the frame was discarded because of the watchdog.
- `busy` out 1: high while the FSM is outside IDLE.
- `frame_count` out 8: number of good frames; wraps 255→0.

## Operation

**Frame format** (8 valid bits, in order):
- Start bit = 1.
- `sel[1]`, `sel[0]`.
- `code[3]`..`code[0]`.
- Parity bit `P`. The XOR of the 6 payload bits and `P` must equal 0 (even parity).

**FSM states:** IDLE, SEL, CODE, PAR.
- IDLE → SEL: on `ser_valid`=1 with `ser_in`=1. When `ser_in`=0 in IDLE, the bit is ignored.
- SEL → CODE: after 2 valid bits. CODE → PAR: after 4 valid bits.
- PAR → IDLE: on the valid parity bit. The parity check is performed in the same cycle.
- Payload bits shift MSB-first into a 6-bit shift register. A 3-bit bit counter counts valid bits only.
- When `ser_valid` is low, state, shift register and bit counter all hold (stall).

**Good parity:**
- Register `select`=`sel` and `code_in`=`code`.
- Pulse `frame_valid`.
- Increment `frame_count`.
- Set `range_err` for that pulse if either:
  - `sel`=01 and `code`>9, or
  - `sel`=11 and (`code`<3 or `code`>12).
- For `sel`=00 and `sel`=10, `range_err` is always 0.

**Bad parity:**
- Pulse `parity_err`.
- `code_in`, `select` and `frame_count` are unchanged.

**Watchdog:**
- The idle counter clears on every valid bit and on entry to IDLE.
- It increments on each `ser_valid`=0 cycle while the FSM is outside IDLE.
- When the count reaches `TIMEOUT`: state → IDLE, the shift register is discarded, and `frame_abort` pulses. Outputs and `frame_count` are unchanged.
- In IDLE the counter is held at 0.

**Pulse exclusivity:** `frame_valid`, `parity_err` and `frame_abort` are mutually exclusive. `range_err` is 0 whenever `frame_valid` is 0.

**Reset** (`rst_n`=0 at an edge), regardless of state, including mid-frame:
- State → IDLE.
- `code_in`=0, `select`=0, `frame_count`=0.
- `frame_valid`, `range_err`, `parity_err`, `frame_abort` and `busy` all 0.
- Counters and shift register cleared.
- The partial frame is lost; no pulse is generated.

## Timing

- All outputs are registered. There is no combinational path from input to output.
- The parity bit is sampled at edge N. At N+1, `code_in`/`select` are new and `frame_valid`/`range_err` (or `parity_err`) are high for exactly one cycle.
- Minimum frame time is 8 cycles. The FSM is in IDLE at N+1, so a start bit sampled at edge N+1 is accepted: back-to-back frames are lossless.
- `busy` rises the cycle after the start bit is sampled and falls the cycle after the parity bit is sampled or the abort occurs.
- Watchdog: the start bit is sampled at edge S, and `ser_valid` is low for every following edge. `frame_abort` is then high from edge S+`TIMEOUT` for one cycle. Exactly `TIMEOUT`−1 idle cycles do not abort.
- `code_in`/`select` hold their values indefinitely between good frames.

## Test plan

- **Good frame:** bits 1,0,0,1,0,1,1,1 (`sel`=00, `code`=1011, P=1) → one cycle after P: `select`=00, `code_in`=1011, `frame_valid`=1, `range_err`=0, `frame_count`=1.
- **Range error, mode 01:** bits 1,0,1,1,1,0,0,1 (`sel`=01, `code`=1100) → `frame_valid`=1 with `range_err`=1, `code_in`=1100.
- **Range checks, mode 11:** `sel`=11 with `code`=0010 → `range_err`=1; `sel`=11 with `code`=0011 → `range_err`=0; `sel`=11 with `code`=1100 → `range_err`=0; `sel`=11 with `code`=1101 → `range_err`=1.
- **Parity error:** the first frame followed by 1,0,0,1,0,1,1,0 → `parity_err` pulses once, `frame_valid` stays 0, `code_in` stays 1011, `frame_count` stays 1.
- **Stall and watchdog:**
  - Insert 3 `ser_valid`=0 cycles between every bit of the good frame → identical result to the good-frame case.
  - With `TIMEOUT`=16, send 1,0,1 then hold `ser_valid` low → `frame_abort` pulses on the 16th idle cycle's edge and `busy` drops.
  - With only 15 idle cycles followed by the remaining bits, the frame completes normally.
- **Back-to-back, wrap and reset:**
  - 256 consecutive good frames with no gaps → every frame strobes and `frame_count` wraps to 0.
  - Assert `rst_n`=0 for 1 cycle after the 4th bit of a frame → all outputs 0 and no pulse; the next full frame decodes correctly.
